// File: rtl/adder_checker_pkg.sv
// Shared definitions for the adder self-test engine: FSM encoding, op-select
// codes, error-counter sizing and the golden adder reference function.
package adder_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int               ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Widest operand the reference function supports.
    localparam int REF_MAX_W = 32;

    // Golden adder result for operands of 'width' bits (width <= REF_MAX_W).
    // Bit 'width' carries the carry (add) or the borrow (subtract); every bit
    // above it is cleared, which gives the mod 2^(width+1) wrap on subtract.
    function automatic logic [REF_MAX_W:0] adder_ref(
        input logic [REF_MAX_W-1:0] a,
        input logic [REF_MAX_W-1:0] b,
        input logic                 sel,
        input int                   width
    );
        logic [REF_MAX_W:0] raw;
        logic [REF_MAX_W:0] mask;
        if (sel == OP_ADD) begin
            raw = {1'b0, a} + {1'b0, b};
        end else begin
            raw = {1'b0, a} - {1'b0, b};
        end
        mask = ((REF_MAX_W+1)'(1) << (width + 1)) - (REF_MAX_W+1)'(1);
        return raw & mask;
    endfunction

endpackage

// File: rtl/adder_vec_gen.sv
// Nested Sel/A/B counters that enumerate every adder test vector.
// B is the innermost loop, then A, then Sel (add pass first, subtract pass second).
module adder_vec_gen
    import adder_checker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sel,
    output logic             last
);

    // The final vector is the subtract pass with both operands all-ones.
    assign last = (sel == OP_SUB) && (&a) && (&b);

    // Advance B each step, carrying into A and then into Sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a   <= '0;
            b   <= '0;
            sel <= OP_ADD;
        end else if (clr) begin
            a   <= '0;
            b   <= '0;
            sel <= OP_ADD;
        end else if (step) begin
            if (&b) begin
                b <= '0;
                if (&a) begin
                    a   <= '0;
                    sel <= ~sel;
                end else begin
                    a <= a + WIDTH'(1);
                end
            end else begin
                b <= b + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/adder_checker.sv
// Self-test engine for the combinational adder. It sweeps every Sel/A/B
// combination into the adder, checks Rez_in against the golden model and
// reports pass/fail, a saturating error count and the first failing vector.
// Optional build macro ADDER_CHECKER_STOP_ON_ERR_EN: when defined, the first
// mismatch ends the sweep immediately; otherwise the full sweep always runs.
// WIDTH must not exceed 32.
module adder_checker
    import adder_checker_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             Clk_in,
    input  logic             Reset_n_in,
    input  logic             Start_in,
    input  logic             Abort_in,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             Sel_out,
    input  logic [WIDTH:0]   Rez_in,
    output logic             Busy_out,
    output logic             Done_out,
    output logic             Pass_out,
    output logic [ERR_W-1:0] Err_cnt_out,
    output logic [WIDTH-1:0] Fail_a_out,
    output logic [WIDTH-1:0] Fail_b_out,
    output logic             Fail_sel_out,
    output logic [WIDTH:0]   Fail_rez_out
);

    // The settle counter runs 0..SETTLE-1; keep at least one bit so SETTLE=0 still elaborates.
    localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t             state;
    state_t             state_nxt;
    logic [SW-1:0]      settle_cnt;
    logic [WIDTH-1:0]   gen_a;
    logic [WIDTH-1:0]   gen_b;
    logic               gen_sel;
    logic               gen_last;
    logic               gen_clr;
    logic               gen_step;
    logic [REF_MAX_W:0] ref_rez;
    logic [REF_MAX_W:0] rez_ext;
    logic               mismatch;
    logic               abort_hit;
    logic               start_ok;
    logic               check_fire;
    logic               stop_hit;
    logic               finish;
    logic [ERR_W-1:0]   err_nxt;

    adder_vec_gen #(
        .WIDTH (WIDTH)
    ) u_vec_gen (
        .clk   (Clk_in),
        .rst_n (Reset_n_in),
        .clr   (gen_clr),
        .step  (gen_step),
        .a     (gen_a),
        .b     (gen_b),
        .sel   (gen_sel),
        .last  (gen_last)
    );

    // The comparison uses the registered operands, i.e. exactly what the adder sees.
    assign ref_rez  = adder_ref(REF_MAX_W'(A_out), REF_MAX_W'(B_out), Sel_out, WIDTH);
    assign rez_ext  = (REF_MAX_W+1)'(Rez_in);
    assign mismatch = (rez_ext != ref_rez);

    // Abort wins over everything, including a start request in the same cycle.
    assign abort_hit  = Abort_in && (state != ST_IDLE);
    assign start_ok   = (state == ST_IDLE) && Start_in && !Abort_in;
    assign check_fire = (state == ST_CHECK) && !Abort_in;

`ifdef ADDER_CHECKER_STOP_ON_ERR_EN
    assign stop_hit = check_fire && mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    assign finish   = check_fire && (gen_last || stop_hit);
    assign gen_clr  = start_ok;
    assign gen_step = check_fire && !stop_hit;

    // Next error count: increment on a checked mismatch, sticking at the maximum.
    always_comb begin
        err_nxt = Err_cnt_out;
        if (check_fire && mismatch && (Err_cnt_out != ERR_MAX)) begin
            err_nxt = Err_cnt_out + ERR_W'(1);
        end
    end

    // Sequence DRIVE -> SETTLE -> CHECK per vector, with abort forcing IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = finish ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Count wait cycles while in SETTLE; idle at zero otherwise.
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Operand drive, error counting, first-failure capture and status flags.
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            A_out        <= '0;
            B_out        <= '0;
            Sel_out      <= 1'b0;
            Busy_out     <= 1'b0;
            Done_out     <= 1'b0;
            Pass_out     <= 1'b0;
            Err_cnt_out  <= '0;
            Fail_a_out   <= '0;
            Fail_b_out   <= '0;
            Fail_sel_out <= 1'b0;
            Fail_rez_out <= '0;
        end else begin
            Done_out <= 1'b0;
            if (start_ok) begin
                Busy_out     <= 1'b1;
                Err_cnt_out  <= '0;
                Fail_a_out   <= '0;
                Fail_b_out   <= '0;
                Fail_sel_out <= 1'b0;
                Fail_rez_out <= '0;
            end
            if ((state == ST_DRIVE) && !Abort_in) begin
                A_out   <= gen_a;
                B_out   <= gen_b;
                Sel_out <= gen_sel;
            end
            if (check_fire) begin
                Err_cnt_out <= err_nxt;
                if (mismatch && (Err_cnt_out == '0)) begin
                    Fail_a_out   <= A_out;
                    Fail_b_out   <= B_out;
                    Fail_sel_out <= Sel_out;
                    Fail_rez_out <= Rez_in;
                end
            end
            if (finish) begin
                Busy_out <= 1'b0;
                Done_out <= 1'b1;
                Pass_out <= (err_nxt == '0);
            end
            if (abort_hit) begin
                Busy_out <= 1'b0;
            end
        end
    end

endmodule
